// File: rtl/simd_exec_pipe.sv
// Registered multi-lane ALU stage (independent or chained lanes) with a per-lane carry register; 1-cycle latency.
// Valid/ready on both sides: a stalled result holds result, valid and carries, and blocks new input.
module simd_exec_pipe #(
  parameter int LANES      = 8,
  parameter int BITS_DATA  = 8,
  parameter int BITS_ALUOP = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [BITS_ALUOP-1:0]        opCode,
  input  logic                         chainMode,
  input  logic                         clearCarry,
  input  logic [LANES*BITS_DATA-1:0]   arrayA,
  input  logic [LANES*BITS_DATA-1:0]   arrayB,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [LANES*BITS_DATA-1:0]   executionResult,
  output logic [LANES-1:0]             carryTotal
);

  localparam int W = LANES * BITS_DATA;

  localparam logic [BITS_ALUOP-1:0] OP_ADD = BITS_ALUOP'(0);
  localparam logic [BITS_ALUOP-1:0] OP_ADC = BITS_ALUOP'(1);
  localparam logic [BITS_ALUOP-1:0] OP_SUB = BITS_ALUOP'(2);
  localparam logic [BITS_ALUOP-1:0] OP_SBB = BITS_ALUOP'(3);
  localparam logic [BITS_ALUOP-1:0] OP_AND = BITS_ALUOP'(4);
  localparam logic [BITS_ALUOP-1:0] OP_OR  = BITS_ALUOP'(5);
  localparam logic [BITS_ALUOP-1:0] OP_XOR = BITS_ALUOP'(6);
  localparam logic [BITS_ALUOP-1:0] OP_NOT = BITS_ALUOP'(7);
  localparam logic [BITS_ALUOP-1:0] OP_SHL = BITS_ALUOP'(8);
  localparam logic [BITS_ALUOP-1:0] OP_SHR = BITS_ALUOP'(9);

  logic                 accept;
  logic                 hold;
  logic                 writesCarry;
  logic                 isArith;
  logic                 isSub;
  logic                 usesStored;
  logic [LANES-1:0]     storedCin;
  logic [W-1:0]         nextResult;
  logic [LANES-1:0]     nextCarry;
  logic [W-1:0]         wordShl;
  logic [W-1:0]         wordShr;
  logic [BITS_DATA-1:0] laneA;
  logic [BITS_DATA-1:0] laneB;
  logic [BITS_DATA-1:0] laneOp;
  logic [BITS_DATA-1:0] laneRes;
  logic [BITS_DATA:0]   laneSum;
  logic                 laneCin;
  logic                 laneCout;
  logic                 ripple;

  assign inReady = !outValid || outReady;
  assign accept  = inValid && inReady;
  assign hold    = outValid && !outReady;

  // A same-cycle clear forces the incoming ADC/SBB to see a zero carry.
  assign storedCin = clearCarry ? '0 : carryTotal;

  always_comb begin
    isArith     = (opCode == OP_ADD) || (opCode == OP_ADC) ||
                  (opCode == OP_SUB) || (opCode == OP_SBB);
    isSub       = (opCode == OP_SUB) || (opCode == OP_SBB);
    usesStored  = (opCode == OP_ADC) || (opCode == OP_SBB);
    writesCarry = isArith || (opCode == OP_SHL) || (opCode == OP_SHR);
    wordShl     = arrayA << 1;
    wordShr     = arrayA >> 1;
    nextResult  = '0;
    nextCarry   = '0;
    ripple      = 1'b0;
    laneA       = '0;
    laneB       = '0;
    laneOp      = '0;
    laneRes     = '0;
    laneSum     = '0;
    laneCin     = 1'b0;
    laneCout    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      laneA = arrayA[i*BITS_DATA +: BITS_DATA];
      laneB = arrayB[i*BITS_DATA +: BITS_DATA];
      // Chained lanes above lane 0 take the previous lane's carry of this same op.
      if (chainMode && (i != 0))
        laneCin = ripple;
      else if (usesStored)
        laneCin = chainMode ? storedCin[LANES-1] : storedCin[i];
      else
        laneCin = isSub;
      laneOp  = isSub ? ~laneB : laneB;
      laneSum = {1'b0, laneA} + {1'b0, laneOp} + {{BITS_DATA{1'b0}}, laneCin};
      ripple  = laneSum[BITS_DATA];
      laneRes  = laneA;
      laneCout = 1'b0;
      case (opCode)
        OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
          laneRes  = laneSum[BITS_DATA-1:0];
          laneCout = laneSum[BITS_DATA];
        end
        OP_AND: laneRes = laneA & laneB;
        OP_OR:  laneRes = laneA | laneB;
        OP_XOR: laneRes = laneA ^ laneB;
        OP_NOT: laneRes = ~laneA;
        OP_SHL: begin
          laneRes  = chainMode ? wordShl[i*BITS_DATA +: BITS_DATA] : (laneA << 1);
          laneCout = laneA[BITS_DATA-1];
        end
        OP_SHR: begin
          laneRes  = chainMode ? wordShr[i*BITS_DATA +: BITS_DATA] : (laneA >> 1);
          laneCout = laneA[0];
        end
        default: laneRes = laneA;
      endcase
      nextResult[i*BITS_DATA +: BITS_DATA] = laneRes;
      nextCarry[i] = laneCout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid        <= 1'b0;
      executionResult <= '0;
      carryTotal      <= '0;
    end else begin
      if (accept) begin
        executionResult <= nextResult;
        outValid        <= 1'b1;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
      if (accept && writesCarry)
        carryTotal <= nextCarry;
      else if (clearCarry && !hold)
        carryTotal <= '0;
    end
  end

endmodule
